// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the MM:SS stopwatch control slice.
// Optional lap-hold feature is enabled with the STOPWATCH_LAP_HOLD_EN macro.
package stopwatch_pkg;

  localparam int DEF_MAX_MIN = 59;
  localparam int DEF_MAX_SEC = 59;
  localparam int DEF_CNT_W   = 8;

  // Encoding is visible on the debug state port and must stay fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ADJ   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_mod_n_counter.sv
// Modulo-(MAX+1) up counter used for both the minutes and seconds fields.
// wrap flags an increment at the terminal value; hold freezes the value so
// the owner can saturate instead of wrapping.
module mod_n_counter #(
  parameter int MAX = 59,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  // Next value: clear wins, then a non-held increment wraps MAX back to 0.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && !hold) begin
      value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = inc & (value_q == MAX_V);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control/sequencing block for the 4-digit MM:SS stopwatch: owns the count,
// runs the IDLE/RUN/PAUSE/ADJ state machine and drives digit-group blanking.
// Define STOPWATCH_LAP_HOLD_EN to add the lap-hold display freeze.
//
// Control inputs are one-cycle pulses (btn_*_p, tick_*) or levels (adj_sw,
// sel_sw) sampled on posedge clk; there is no handshaking, every output is a
// register updated on the edge that samples the causing input.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_blink,
  input  logic             btn_pause_p,
  input  logic             btn_clr_p,
  input  logic             btn_inc_p,
  input  logic             adj_sw,
  input  logic             sel_sw,
  output logic [CNT_W-1:0] minutes,
  output logic [CNT_W-1:0] seconds,
  output logic             blank_min,
  output logic             blank_sec,
  output logic             running,
  output logic [1:0]       state,
  output logic             full_p
`ifdef STOPWATCH_LAP_HOLD_EN
  ,
  input  logic             btn_lap_p,
  output logic             lap_active
`endif
);

  sw_state_e state_d, state_q;
  logic      blink_d, blink_q;
  logic      blank_min_d, blank_min_q;
  logic      blank_sec_d, blank_sec_q;
  logic      running_d, running_q;
  logic      full_d, full_q;

  logic             run_tick;
  logic             adj_live;
  logic             adj_sec_inc;
  logic             adj_min_inc;
  logic             sec_inc;
  logic             min_inc;
  logic             sec_wrap;
  logic             min_wrap;
  logic             sat_hold;
  logic [CNT_W-1:0] min_val;
  logic [CNT_W-1:0] sec_val;

  // Counter controls. A clear discards every other event in the cycle, and
  // leaving ADJ (adj_sw low) takes priority over an increment.
  assign run_tick    = (state_q == ST_RUN) & ~btn_clr_p & tick_1hz;
  assign adj_live    = (state_q == ST_ADJ) & ~btn_clr_p & adj_sw;
  assign adj_sec_inc = adj_live & btn_inc_p & ~sel_sw;
  assign adj_min_inc = adj_live & btn_inc_p & sel_sw;
  assign sec_inc     = run_tick | adj_sec_inc;
  assign min_inc     = (run_tick & sec_wrap) | adj_min_inc;
  // In RUN a minutes wrap can only come from a tick at MAX_MIN:MAX_SEC,
  // which must saturate rather than roll over to 00:00.
  assign sat_hold    = run_tick & min_wrap;

  mod_n_counter #(
    .MAX (MAX_SEC),
    .W   (CNT_W)
  ) u_sec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (btn_clr_p),
    .inc   (sec_inc),
    .hold  (sat_hold),
    .value (sec_val),
    .wrap  (sec_wrap)
  );

  mod_n_counter #(
    .MAX (MAX_MIN),
    .W   (CNT_W)
  ) u_min_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (btn_clr_p),
    .inc   (min_inc),
    .hold  (sat_hold),
    .value (min_val),
    .wrap  (min_wrap)
  );

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    full_d  = sat_hold;
    if (btn_clr_p) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (adj_sw)           state_d = ST_ADJ;
          else if (btn_pause_p) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (sat_hold || btn_pause_p) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (adj_sw)           state_d = ST_ADJ;
          else if (btn_pause_p) state_d = ST_RUN;
        end
        ST_ADJ: begin
          if (!adj_sw) state_d = ST_PAUSE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Blink phase only advances while staying in ADJ, so every entry into
    // ADJ starts with the selected field visible.
    blink_d     = (state_q == ST_ADJ && state_d == ST_ADJ) ? (blink_q ^ tick_blink) : 1'b0;
    blank_min_d = (state_d == ST_ADJ) & sel_sw & blink_d;
    blank_sec_d = (state_d == ST_ADJ) & ~sel_sw & blink_d;
    running_d   = (state_d == ST_RUN);
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blink_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
      running_q   <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_q     <= blink_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
      running_q   <= running_d;
      full_q      <= full_d;
    end
  end

  assign state     = state_q;
  assign running   = running_q;
  assign full_p    = full_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic             lap_active_d, lap_active_q;
  logic [CNT_W-1:0] lap_min_d, lap_min_q;
  logic [CNT_W-1:0] lap_sec_d, lap_sec_q;

  // Lap toggle: first press snapshots the live count, second press releases.
  // Any exit from RUN (including clear) drops the hold.
  always_comb begin
    lap_active_d = lap_active_q;
    lap_min_d    = lap_min_q;
    lap_sec_d    = lap_sec_q;
    if (state_q == ST_RUN && btn_lap_p) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else begin
        lap_active_d = 1'b1;
        lap_min_d    = min_val;
        lap_sec_d    = sec_val;
      end
    end
    if (state_d != ST_RUN) begin
      lap_active_d = 1'b0;
    end
  end

  // Lap snapshot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_active_q <= 1'b0;
      lap_min_q    <= '0;
      lap_sec_q    <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      lap_min_q    <= lap_min_d;
      lap_sec_q    <= lap_sec_d;
    end
  end

  assign lap_active = lap_active_q;
  assign minutes    = lap_active_q ? lap_min_q : min_val;
  assign seconds    = lap_active_q ? lap_sec_q : sec_val;
`else
  assign minutes = min_val;
  assign seconds = sec_val;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control/sequencing block for the 4-digit MM:SS stopwatch.
- Owns the minutes/seconds count registers that feed the multiplexed 7-segment display driver.
- Interprets one-cycle button pulses and mode switches, and advances time on a 1 Hz enable.
- Provides digit-group blanking so the display blinks the field being adjusted.

Parameters:
- MAX_MIN, 59: terminal value of the minutes field (binary).
- MAX_SEC, 59: terminal value of the seconds field (binary).
- CNT_W, 8: width of the minutes and seconds outputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk only.
- tick_1hz  in  1  one-cycle count enable, 1 Hz.
- tick_blink  in  1  one-cycle blink-phase enable, 2 Hz.
- btn_pause_p  in  1  debounced one-cycle pulse: start/stop.
- btn_clr_p  in  1  debounced one-cycle pulse: clear to 00:00.
- btn_inc_p  in  1  debounced one-cycle pulse: increment the selected field (ADJ state only).
- adj_sw  in  1  level: request adjust mode.
- sel_sw  in  1  level: 1 = minutes selected, 0 = seconds selected.
- minutes  out  CNT_W  binary 0..MAX_MIN, to the display driver.
- seconds  out  CNT_W  binary 0..MAX_SEC, to the display driver.
- blank_min  out  1  high = display blanks both minute digits.
- blank_sec  out  1  high = display blanks both second digits.
- running  out  1  high while in RUN.
- state  out  2  current FSM state (debug).
- full_p  out  1  one-cycle pulse when the count saturates at MAX_MIN:MAX_SEC.

Behaviour:
- Reset (rst_n=0 at posedge):
  - minutes=0, seconds=0, state=IDLE, blink_phase=0.
  - blank_min=0, blank_sec=0, running=0, full_p=0.
- All outputs are registered; each update is visible the cycle after the causing input.
- FSM encoding: IDLE=0, RUN=1, PAUSE=2, ADJ=3.
- Priority each cycle: btn_clr_p > adj_sw entry/exit > btn_pause_p > tick_1hz/btn_inc_p.
- btn_clr_p, any state: minutes=seconds=0, state goes to IDLE. Any other event in the same cycle is discarded.
- IDLE:
  - btn_pause_p moves to RUN.
  - adj_sw=1 moves to ADJ.
- RUN:
  - tick_1hz increments seconds.
  - seconds==MAX_SEC wraps seconds to 0 and increments minutes.
  - adj_sw is ignored in RUN.
  - btn_pause_p moves to PAUSE. If tick_1hz coincides with it, the tick is still applied in that cycle.
  - Saturation: a tick at MAX_MIN:MAX_SEC holds the count, asserts full_p for one cycle, and moves to PAUSE.
- PAUSE:
  - Count frozen; tick_1hz ignored.
  - btn_pause_p moves to RUN.
  - adj_sw=1 moves to ADJ.
  - If both fire in the same cycle, ADJ wins.
- ADJ:
  - btn_inc_p increments the field selected by sel_sw.
  - The incremented field wraps MAX to 0 with no carry into the other field.
  - tick_1hz and btn_pause_p are ignored.
  - adj_sw=0 moves to PAUSE.
  - sel_sw may change at any time and takes effect the same cycle.
- Blink:
  - blink_phase toggles on tick_blink only while in ADJ, and is forced to 0 outside ADJ.
  - blank_min = ADJ & sel_sw & blink_phase.
  - blank_sec = ADJ & ~sel_sw & blink_phase.
- Entering ADJ always starts with the selected field visible (blink_phase=0).
- Counts never exceed MAX_*; values loaded by any path are always in range.
- rst_n low during any state overrides everything on that edge.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds input btn_lap_p (1-bit pulse) and output lap_active (1-bit).
  - In RUN, btn_lap_p latches the current count into lap registers and sets lap_active=1. minutes/seconds then show the lap value while the internal count keeps running.
  - A second btn_lap_p clears lap_active and returns to the live count.
  - btn_clr_p, reset, or leaving RUN clears lap_active.
- Undefined: neither port exists; minutes/seconds always show the live count.

Decomposition:
- Shared package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/ADJ, 2-bit);
  - constants for the default MAX_MIN/MAX_SEC and CNT_W.
- Sub-module mod_n_counter is used for both fields:
  - inputs: clk, rst_n, clr, inc, parameter MAX;
  - outputs: value, wrap (combinational, inc & value==MAX);
  - a hold input suppresses wrap-to-0 for saturation.

Test Plan:
- Reset then btn_pause_p, then 75 tick_1hz → minutes=1, seconds=15, running=1, state=RUN.
- From 00:59 in RUN, tick_1hz with btn_pause_p in the same cycle → 01:00 next cycle, state=PAUSE, further ticks ignored.
- Preload to 59:58, run 2 ticks → 59:59 then full_p=1 for one cycle, count holds 59:59, state=PAUSE.
- PAUSE, adj_sw=1, sel_sw=0, seconds=58, 3×btn_inc_p → seconds=1, minutes unchanged. blank_sec toggles on each tick_blink; blank_min stays 0.
- In ADJ, btn_clr_p with btn_inc_p in the same cycle → 00:00, state=IDLE, blank_min=blank_sec=0.
- STOPWATCH_LAP_HOLD_EN: at 00:10 press btn_lap_p, run 5 ticks → outputs stay 00:10. A second btn_lap_p → outputs 00:15, lap_active=0.
